// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the load/store path and data_mem_ctrl.
interface data_mem_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [BE_W-1:0]   req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data RAM behind a valid/ready port with byte-lane writes,
// WAIT_CYCLES wait states and address error reporting.
// Optional memory-mapped output register: define DATA_MEM_CTRL_MMIO_EN.
module data_mem_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
`ifdef DATA_MEM_CTRL_MMIO_EN
  ,
  parameter logic [ADDR_W-1:0] MMIO_ADDR = ADDR_W'(32'hFFFF_FFFC)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  data_mem_ctrl_if.slave    bus
`ifdef DATA_MEM_CTRL_MMIO_EN
  ,
  output logic [DATA_W-1:0] mmio_out
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam logic [63:0] MEM_LIMIT = 64'(DEPTH) * 64'(BE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef DATA_MEM_CTRL_MMIO_EN
  logic [DATA_W-1:0] mmio_q, mmio_d;
  logic              mmio_hit_c;
`endif

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              t_we_c;
  logic [BE_W-1:0]   t_be_c;
  logic [ADDR_W-1:0] t_addr_c;
  logic [DATA_W-1:0] t_wdata_c;
  logic [IDX_W-1:0]  idx_c;
  logic              misalign_c;
  logic              oor_c;
  logic              err_c;
  logic [DATA_W-1:0] rd_c;
  logic              enter_resp_c;
  logic              mem_we_c;

  // Transaction seen by the commit logic: live inputs when committing straight
  // from IDLE (WAIT_CYCLES == 0), otherwise the latched copy.
  always_comb begin
    t_we_c    = we_q;
    t_be_c    = be_q;
    t_addr_c  = addr_q;
    t_wdata_c = wdata_q;
    if (state_q == S_IDLE) begin
      t_we_c    = bus.req_we;
      t_be_c    = bus.req_be;
      t_addr_c  = bus.req_addr;
      t_wdata_c = bus.req_wdata;
    end
  end

  // Address decode and error classification.
  always_comb begin
    idx_c      = t_addr_c[IDX_W+1:2];
    misalign_c = (t_addr_c[1:0] != 2'b00);
    oor_c      = (64'(t_addr_c) >= MEM_LIMIT);
    rd_c       = mem_q[idx_c];
`ifdef DATA_MEM_CTRL_MMIO_EN
    mmio_hit_c = (t_addr_c == MMIO_ADDR);
    err_c      = !mmio_hit_c && (misalign_c || oor_c);
    if (mmio_hit_c) begin
      rd_c = mmio_q;
    end
`else
    err_c      = misalign_c || oor_c;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ready_d      = 1'b0;
    rsp_valid_d  = 1'b0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    enter_resp_c = 1'b0;
    mem_we_c     = 1'b0;
`ifdef DATA_MEM_CTRL_MMIO_EN
    mmio_d       = mmio_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && ready_q) begin
          we_d    = bus.req_we;
          be_d    = bus.req_be;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = '0;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
          end else begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d      = S_RESP;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_resp_c) begin
      rsp_valid_d = 1'b1;
      err_d       = err_c;
      rdata_d     = '0;
      if (!err_c && !t_we_c) begin
        rdata_d = rd_c;
      end
`ifdef DATA_MEM_CTRL_MMIO_EN
      mem_we_c = t_we_c && !err_c && !mmio_hit_c;
      if (t_we_c && mmio_hit_c) begin
        for (int b = 0; b < int'(BE_W); b++) begin
          if (t_be_c[b]) begin
            mmio_d[b*8 +: 8] = t_wdata_c[b*8 +: 8];
          end
        end
      end
`else
      mem_we_c = t_we_c && !err_c;
`endif
    end

    ready_d = (state_d == S_IDLE);
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef DATA_MEM_CTRL_MMIO_EN
      mmio_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef DATA_MEM_CTRL_MMIO_EN
      mmio_q      <= mmio_d;
`endif
    end
  end

  // Byte-lane RAM write; reset blocks an uncommitted write, contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && mem_we_c) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (t_be_c[b]) begin
          mem_q[idx_c][b*8 +: 8] <= t_wdata_c[b*8 +: 8];
        end
      end
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
`ifdef DATA_MEM_CTRL_MMIO_EN
  assign mmio_out      = mmio_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=0 for back-to-back traffic.
module tb_data_mem_ctrl;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();
  data_mem_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();

`ifdef DATA_MEM_CTRL_MMIO_EN
  logic [31:0] mmio1;
  logic [31:0] mmio0;
`endif

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(1)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus1)
`ifdef DATA_MEM_CTRL_MMIO_EN
    ,
    .mmio_out (mmio1)
`endif
  );

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus0)
`ifdef DATA_MEM_CTRL_MMIO_EN
    ,
    .mmio_out (mmio0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the WAIT_CYCLES=1 instance, checking handshake timing.
  task automatic txn1(input string tag, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    int lat;
    check({tag, "_ready_pre"}, 32'(bus1.req_ready), 32'd1);
    bus1.req_valid = 1'b1;
    bus1.req_we    = we;
    bus1.req_be    = be;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    step();
    bus1.req_valid = 1'b0;
    bus1.req_we    = 1'b0;
    bus1.req_be    = 4'h0;
    bus1.req_addr  = 32'h0;
    bus1.req_wdata = 32'h0;
    lat = 1;
    while (bus1.rsp_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_ready_in_resp"}, 32'(bus1.req_ready), 32'd0);
    rdata = bus1.rsp_rdata;
    err   = bus1.rsp_err;
    step();
    check({tag, "_pulse_one_cycle"}, 32'(bus1.rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        b2b_we   [4];
  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_wd   [4];
  logic [31:0] b2b_exp  [4];

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_be = 4'h0;
    bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_be = 4'h0;
    bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;

    // Reset values
    step();
    step();
    check("rst_ready", 32'(bus1.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
    check("rst_rdata", bus1.rsp_rdata, 32'h0);
    check("rst_err", 32'(bus1.rsp_err), 32'd0);
    check("rst_ready0", 32'(bus0.req_ready), 32'd1);
    reset = 1'b1;
    step();

    // Full-word write then immediate read-back
    txn1("w10", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er);
    check("w10_err", 32'(er), 32'd0);
    check("w10_rdata", rd, 32'h0);
    txn1("r10", 1'b0, 4'h0, 32'h10, 32'h0, rd, er);
    check("r10_err", 32'(er), 32'd0);
    check("r10_rdata", rd, 32'hDEADBEEF);

    // Byte-lane merge
    txn1("w20a", 1'b1, 4'hF, 32'h20, 32'h11223344, rd, er);
    txn1("w20b", 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, er);
    check("w20b_err", 32'(er), 32'd0);
    txn1("r20", 1'b0, 4'h0, 32'h20, 32'h0, rd, er);
    check("r20_rdata", rd, 32'h11BB33DD);

    // be=0 write is a legal no-op
    txn1("w20z", 1'b1, 4'h0, 32'h20, 32'hFFFFFFFF, rd, er);
    check("w20z_err", 32'(er), 32'd0);
    txn1("r20z", 1'b0, 4'h0, 32'h20, 32'h0, rd, er);
    check("r20z_rdata", rd, 32'h11BB33DD);

    // Last legal word
    txn1("wfc", 1'b1, 4'hF, 32'hFC, 32'h0F0F0F0F, rd, er);
    check("wfc_err", 32'(er), 32'd0);
    txn1("rfc", 1'b0, 4'h0, 32'hFC, 32'h0, rd, er);
    check("rfc_rdata", rd, 32'h0F0F0F0F);

    // Errors: out of range, misaligned; no aliasing onto word 0
    txn1("w00", 1'b1, 4'hF, 32'h0, 32'h12345678, rd, er);
    txn1("r102", 1'b0, 4'h0, 32'h102, 32'h0, rd, er);
    check("r102_err", 32'(er), 32'd1);
    check("r102_rdata", rd, 32'h0);
    txn1("w100", 1'b1, 4'hF, 32'h100, 32'hFFFFFFFF, rd, er);
    check("w100_err", 32'(er), 32'd1);
    txn1("r00", 1'b0, 4'h0, 32'h0, 32'h0, rd, er);
    check("r00_err", 32'(er), 32'd0);
    check("r00_rdata", rd, 32'h12345678);
    txn1("r11", 1'b0, 4'h0, 32'h11, 32'h0, rd, er);
    check("r11_err", 32'(er), 32'd1);
    check("r11_rdata", rd, 32'h0);
    txn1("w80000000", 1'b1, 4'hF, 32'h8000_0010, 32'h55555555, rd, er);
    check("w80000000_err", 32'(er), 32'd1);
    txn1("r10b", 1'b0, 4'h0, 32'h10, 32'h0, rd, er);
    check("r10b_rdata", rd, 32'hDEADBEEF);

    // Reset during WAIT discards the write and the response
    txn1("w08", 1'b1, 4'hF, 32'h8, 32'h5, rd, er);
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b1;
    bus1.req_be    = 4'hF;
    bus1.req_addr  = 32'h8;
    bus1.req_wdata = 32'h99;
    step();
    check("midrst_in_wait_ready", 32'(bus1.req_ready), 32'd0);
    bus1.req_valid = 1'b0;
    bus1.req_we    = 1'b0;
    reset = 1'b0;
    step();
    check("midrst_rsp_valid_a", 32'(bus1.rsp_valid), 32'd0);
    reset = 1'b1;
    step();
    check("midrst_rsp_valid_b", 32'(bus1.rsp_valid), 32'd0);
    check("midrst_ready", 32'(bus1.req_ready), 32'd1);
    txn1("r08", 1'b0, 4'h0, 32'h8, 32'h0, rd, er);
    check("r08_rdata", rd, 32'h5);

    // Memory-mapped register at 0xFFFF_FFFC
    txn1("wmmio", 1'b1, 4'hF, 32'hFFFF_FFFC, 32'h0000_00A5, rd, er);
`ifdef DATA_MEM_CTRL_MMIO_EN
    check("wmmio_err", 32'(er), 32'd0);
    check("mmio_out", mmio1, 32'h0000_00A5);
    txn1("rmmio", 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0, rd, er);
    check("rmmio_rdata", rd, 32'h0000_00A5);
    check("rmmio_err", 32'(er), 32'd0);
`else
    check("wmmio_err", 32'(er), 32'd1);
    check("wmmio_rdata", rd, 32'h0);
`endif

    // Back-to-back on WAIT_CYCLES=0 with req_valid held high
    b2b_we[0] = 1'b1; b2b_addr[0] = 32'h40; b2b_wd[0] = 32'hCAFE0001; b2b_exp[0] = 32'h0;
    b2b_we[1] = 1'b0; b2b_addr[1] = 32'h40; b2b_wd[1] = 32'h0;        b2b_exp[1] = 32'hCAFE0001;
    b2b_we[2] = 1'b1; b2b_addr[2] = 32'h44; b2b_wd[2] = 32'h0BAD0002; b2b_exp[2] = 32'h0;
    b2b_we[3] = 1'b0; b2b_addr[3] = 32'h44; b2b_wd[3] = 32'h0;        b2b_exp[3] = 32'h0BAD0002;
    bus0.req_valid = 1'b1;
    bus0.req_be    = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bus0.req_we    = b2b_we[k];
      bus0.req_addr  = b2b_addr[k];
      bus0.req_wdata = b2b_wd[k];
      check($sformatf("b2b%0d_ready_idle", k), 32'(bus0.req_ready), 32'd1);
      check($sformatf("b2b%0d_valid_idle", k), 32'(bus0.rsp_valid), 32'd0);
      step();
      check($sformatf("b2b%0d_rsp_valid", k), 32'(bus0.rsp_valid), 32'd1);
      check($sformatf("b2b%0d_ready_resp", k), 32'(bus0.req_ready), 32'd0);
      check($sformatf("b2b%0d_rdata", k), bus0.rsp_rdata, b2b_exp[k]);
      check($sformatf("b2b%0d_err", k), 32'(bus0.rsp_err), 32'd0);
      step();
    end
    bus0.req_valid = 1'b0;
    step();
    check("b2b_idle_after", 32'(bus0.rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
